// File: rtl/multicycle_ctrl.sv
// Multicycle RISC-V style control unit: FETCH/DECODE/EXEC/MEM/WB/TRAP sequencer
// that drives the datapath strobes and counts retired instructions.
module multicycle_ctrl #(
  parameter int unsigned TRAP_ON_ILLEGAL = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [6:0]  opcode,
  input  logic        instr_valid,
  input  logic        mem_ready,
  input  logic        br_taken,
  output logic        imem_req,
  output logic        ir_we,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic        reg_we,
  output logic        pc_we,
  output logic [1:0]  pc_sel,
  output logic [1:0]  wb_sel,
  output logic        alu_src_b,
  output logic        illegal,
  output logic [31:0] instret
);

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  typedef enum logic [2:0] {
    S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_TRAP
  } state_t;

  state_t      state_q, state_d;
  logic [6:0]  opcode_q, opcode_d;
  logic        illegal_q, illegal_d;
  logic [31:0] instret_q, instret_d;

  logic is_r, is_load, is_store, is_branch, is_jal, is_jalr, is_legal;

  always_comb begin
    is_r      = (opcode_q == OP_R);
    is_load   = (opcode_q == OP_LOAD);
    is_store  = (opcode_q == OP_STORE);
    is_branch = (opcode_q == OP_BRANCH);
    is_jal    = (opcode_q == OP_JAL);
    is_jalr   = (opcode_q == OP_JALR);
    is_legal  = is_r || is_load || is_store || is_branch || is_jal || is_jalr ||
                (opcode_q == OP_I) || (opcode_q == OP_LUI) || (opcode_q == OP_AUIPC);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= S_FETCH;
      opcode_q  <= '0;
      illegal_q <= 1'b0;
      instret_q <= '0;
    end else begin
      state_q   <= state_d;
      opcode_q  <= opcode_d;
      illegal_q <= illegal_d;
      instret_q <= instret_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    opcode_d = opcode_q;
    case (state_q)
      S_FETCH: begin
        if (instr_valid) begin
          opcode_d = opcode;
          state_d  = S_DECODE;
        end
      end
      S_DECODE: begin
        if (is_legal)                  state_d = S_EXEC;
        else if (TRAP_ON_ILLEGAL != 0) state_d = S_TRAP;
        else                           state_d = S_FETCH;
      end
      S_EXEC: begin
        if (is_load || is_store) state_d = S_MEM;
        else if (is_branch)      state_d = S_FETCH;
        else                     state_d = S_WB;
      end
      S_MEM: begin
        if (mem_ready) state_d = is_load ? S_WB : S_FETCH;
      end
      S_WB:    state_d = S_FETCH;
      S_TRAP:  state_d = S_TRAP;
      default: state_d = S_FETCH;
    endcase
  end

  logic       imem_req_c, ir_we_c, dmem_req_c, dmem_we_c, reg_we_c, pc_we_c, alu_src_b_c;
  logic [1:0] pc_sel_c, wb_sel_c;

  always_comb begin
    imem_req_c  = 1'b0;
    ir_we_c     = 1'b0;
    dmem_req_c  = 1'b0;
    dmem_we_c   = 1'b0;
    reg_we_c    = 1'b0;
    pc_we_c     = 1'b0;
    alu_src_b_c = 1'b0;
    pc_sel_c    = 2'b00;
    wb_sel_c    = 2'b00;
    case (state_q)
      S_FETCH: begin
        imem_req_c = 1'b1;
        ir_we_c    = instr_valid;
      end
      S_DECODE: pc_we_c = !is_legal && (TRAP_ON_ILLEGAL == 0);
      S_EXEC: begin
        alu_src_b_c = !is_r && !is_branch;
        if (is_branch) begin
          pc_we_c  = 1'b1;
          pc_sel_c = br_taken ? 2'b01 : 2'b00;
        end
      end
      S_MEM: begin
        dmem_req_c = 1'b1;
        dmem_we_c  = is_store;
        pc_we_c    = is_store && mem_ready;
      end
      S_WB: begin
        reg_we_c = 1'b1;
        pc_we_c  = 1'b1;
        wb_sel_c = is_load ? 2'b01 : ((is_jal || is_jalr) ? 2'b10 : 2'b00);
        pc_sel_c = is_jal ? 2'b01 : (is_jalr ? 2'b10 : 2'b00);
      end
      default: ;
    endcase
  end

  // Outputs are forced low while rst_n is held, so FETCH's imem_req only appears after release.
  always_comb begin
    imem_req  = rst_n & imem_req_c;
    ir_we     = rst_n & ir_we_c;
    dmem_req  = rst_n & dmem_req_c;
    dmem_we   = rst_n & dmem_we_c;
    reg_we    = rst_n & reg_we_c;
    pc_we     = rst_n & pc_we_c;
    alu_src_b = rst_n & alu_src_b_c;
    pc_sel    = rst_n ? pc_sel_c : 2'b00;
    wb_sel    = rst_n ? wb_sel_c : 2'b00;
    illegal   = rst_n & illegal_q;
    instret   = rst_n ? instret_q : '0;
  end

  always_comb begin
    illegal_d = illegal_q || (state_d == S_TRAP);
    instret_d = instret_q + {31'b0, pc_we};
  end

endmodule
